regfile_mp_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 29 ++
 rtl/rf_read_port.sv | 47 ++++
 rtl/regfile_mp_sb.sv | 112 +++++++++++
 tb/tb_regfile_mp_sb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and the bypass-select encoding for the
// multi-port register file with scoreboard.
package regfile_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

   typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
   typedef logic [DEF_DATA_W-1:0] data_word_t;

   typedef enum logic [1:0] {
      BYP_ZERO  = 2'd0,
      BYP_WR0   = 2'd1,
      BYP_WR1   = 2'd2,
      BYP_ARRAY = 2'd3
   } byp_sel_e;

   // The ALU write is younger than the long-latency writeback, so it wins.
   function automatic byp_sel_e byp_sel(input logic is_zero,
                                        input logic wr0_hit,
                                        input logic wr1_hit);
      if (is_zero)      return BYP_ZERO;
      else if (wr0_hit) return BYP_WR0;
      else if (wr1_hit) return BYP_WR1;
      else              return BYP_ARRAY;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: bypass priority mux over the register
// array plus the per-port hazard (busy) indication.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = 0
) (
   input  logic [ADDR_W-1:0]                rd_addr_i,
   input  logic                             wr0_en_i,
   input  logic [ADDR_W-1:0]                wr0_addr_i,
   input  logic [DATA_W-1:0]                wr0_data_i,
   input  logic                             wr1_en_i,
   input  logic [ADDR_W-1:0]                wr1_addr_i,
   input  logic [DATA_W-1:0]                wr1_data_i,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
   input  logic [NUM_REGS-1:0]              busy_i,
   output logic [DATA_W-1:0]                rd_data_o,
   output logic                             rd_busy_o
);

   logic     is_zero;
   logic     wr0_hit;
   logic     wr1_hit;
   byp_sel_e sel;

   assign is_zero = (ZERO_REG != 0) && (rd_addr_i == '0);
   assign wr0_hit = wr0_en_i && (wr0_addr_i == rd_addr_i);
   assign wr1_hit = wr1_en_i && (wr1_addr_i == rd_addr_i);
   assign sel     = byp_sel(is_zero, wr0_hit, wr1_hit);

   always_comb begin
      rd_data_o = regs_i[rd_addr_i];
      case (sel)
         BYP_ZERO: rd_data_o = '0;
         BYP_WR0:  rd_data_o = wr0_data_i;
         BYP_WR1:  rd_data_o = wr1_data_i;
         default:  rd_data_o = regs_i[rd_addr_i];
      endcase
   end

   // A same-cycle writeback releases the hazard because its data is bypassed.
   assign rd_busy_o = busy_i[rd_addr_i] && !wr1_hit && !is_zero;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with ALU and long-latency write ports,
// write-to-read bypass and a pending-destination scoreboard.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wr0_en,
   input  logic [ADDR_W-1:0]          wr0_addr,
   input  logic [DATA_W-1:0]          wr0_data,
   input  logic                       wr1_en,
   input  logic [ADDR_W-1:0]          wr1_addr,
   input  logic [DATA_W-1:0]          wr1_data,
   input  logic                       iss_en,
   input  logic [ADDR_W-1:0]          iss_addr,
   output logic [NUM_REGS-1:0]        busy_vec,
   output logic [ADDR_W:0]            busy_cnt,
   output logic                       err_wb_idle
);

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]             busy_q, busy_d;
   logic [NUM_REGS-1:0]             set_vec, clr_vec;
   logic [ADDR_W:0]                 cnt_q, cnt_d;
   logic                            err_q, err_d;
   logic                            inc, dec;

   always_comb begin
      regs_d = regs_q;
      if (wr1_en) regs_d[wr1_addr] = wr1_data;
      if (wr0_en) regs_d[wr0_addr] = wr0_data;
      if (ZERO_REG != 0) regs_d[0] = '0;
   end

   // Issue beats writeback on the same register: the new op is now in flight.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_en) set_vec[iss_addr] = 1'b1;
      if (wr1_en) clr_vec[wr1_addr] = 1'b1;
      if (ZERO_REG != 0) begin
         set_vec[0] = 1'b0;
         clr_vec[0] = 1'b0;
      end
      busy_d = (busy_q & ~clr_vec) | set_vec;
   end

   always_comb begin
      inc   = |(set_vec & ~busy_q);
      dec   = |(clr_vec & ~set_vec & busy_q);
      cnt_d = cnt_q;
      if (inc && !dec)      cnt_d = cnt_q + CNT_ONE;
      else if (dec && !inc) cnt_d = cnt_q - CNT_ONE;
   end

   always_comb begin
      err_d = err_q;
      if (wr1_en && !busy_q[wr1_addr] && !((ZERO_REG != 0) && (wr1_addr == '0)))
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_q <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      rf_read_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .rd_addr_i  (rd_addr[i*ADDR_W +: ADDR_W]),
         .wr0_en_i   (wr0_en),
         .wr0_addr_i (wr0_addr),
         .wr0_data_i (wr0_data),
         .wr1_en_i   (wr1_en),
         .wr1_addr_i (wr1_addr),
         .wr1_data_i (wr1_data),
         .regs_i     (regs_q),
         .busy_i     (busy_q),
         .rd_data_o  (rd_data[i*DATA_W +: DATA_W]),
         .rd_busy_o  (rd_busy[i])
      );
   end

   assign busy_vec    = busy_q;
   assign busy_cnt    = cnt_q;
   assign err_wb_idle = err_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (ZERO_REG=1, two read ports).
module tb_regfile_mp_sb;
   import regfile_pkg::*;

   localparam int DW = 16;
   localparam int NR = 16;
   localparam int AW = 4;
   localparam int NP = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP*AW-1:0] rd_addr;
   logic [NP*DW-1:0] rd_data;
   logic [NP-1:0]    rd_busy;
   logic             wr0_en, wr1_en, iss_en;
   logic [AW-1:0]    wr0_addr, wr1_addr, iss_addr;
   logic [DW-1:0]    wr0_data, wr1_data;
   logic [NR-1:0]    busy_vec;
   logic [AW:0]      busy_cnt;
   logic             err_wb_idle;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_mp_sb #(
      .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .busy_vec(busy_vec), .busy_cnt(busy_cnt), .err_wb_idle(err_wb_idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
      wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
      wr0_data = '0; wr1_data = '0;
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   initial begin
      data_word_t rd0, rd1;
      idle();
      set_rd(4'd0, 4'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset_busy_vec", 32'(busy_vec), 32'h0);
      check("reset_busy_cnt", 32'(busy_cnt), 32'h0);
      check("reset_err", 32'(err_wb_idle), 32'h0);

      // wr0 bypass then array read
      @(negedge clk);
      wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 16'hABCD;
      set_rd(4'd4, 4'd3);
      #1;
      check("byp_wr0_same_cycle", 32'(rd_data[15:0]), 32'hABCD);
      @(negedge clk);
      idle();
      #1;
      check("byp_wr0_next_cycle", 32'(rd_data[15:0]), 32'hABCD);

      // scoreboard set then writeback release
      @(negedge clk);
      iss_en = 1'b1; iss_addr = 4'd9;
      set_rd(4'd9, 4'd4);
      edge_settle();
      check("sb_busy9", 32'(busy_vec[9]), 32'h1);
      check("sb_cnt1", 32'(busy_cnt), 32'h1);
      check("sb_rd_busy", 32'(rd_busy[0]), 32'h1);
      @(negedge clk);
      idle();
      wr1_en = 1'b1; wr1_addr = 4'd9; wr1_data = 16'h0042;
      #1;
      check("sb_wb_rd_busy", 32'(rd_busy[0]), 32'h0);
      check("sb_wb_bypass", 32'(rd_data[15:0]), 32'h0042);
      edge_settle();
      check("sb_cnt0", 32'(busy_cnt), 32'h0);
      check("sb_vec0", 32'(busy_vec), 32'h0);
      @(negedge clk);
      idle();
      #1;
      check("sb_r9_array", 32'(rd_data[15:0]), 32'h0042);
      check("sb_err_clean", 32'(err_wb_idle), 32'h0);

      // simultaneous set/clear
      @(negedge clk);
      iss_en = 1'b1; iss_addr = 4'd2;
      edge_settle();
      check("sc_cnt_r2", 32'(busy_cnt), 32'h1);
      @(negedge clk);
      iss_en = 1'b1; iss_addr = 4'd2;
      wr1_en = 1'b1; wr1_addr = 4'd2; wr1_data = 16'h5555;
      edge_settle();
      check("sc_same_busy2", 32'(busy_vec[2]), 32'h1);
      check("sc_same_cnt", 32'(busy_cnt), 32'h1);
      @(negedge clk);
      iss_en = 1'b1; iss_addr = 4'd3;
      wr1_en = 1'b1; wr1_addr = 4'd2; wr1_data = 16'h6666;
      edge_settle();
      check("sc_diff_vec", 32'(busy_vec), 32'h0008);
      check("sc_diff_cnt", 32'(busy_cnt), 32'h1);
      @(negedge clk);
      idle();
      iss_en = 1'b1; iss_addr = 4'd3;
      edge_settle();
      check("sc_waw_cnt", 32'(busy_cnt), 32'h1);
      @(negedge clk);
      idle();
      wr1_en = 1'b1; wr1_addr = 4'd3; wr1_data = 16'h3333;
      edge_settle();
      check("sc_drain_cnt", 32'(busy_cnt), 32'h0);
      check("sc_err_still0", 32'(err_wb_idle), 32'h0);

      // register 0 hardwired
      @(negedge clk);
      idle();
      wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 16'hFFFF;
      set_rd(4'd0, 4'd2);
      #1;
      check("z_r0_bypass", 32'(rd_data[15:0]), 32'h0);
      check("z_r2_array", 32'(rd_data[31:16]), 32'h6666);
      @(negedge clk);
      idle();
      iss_en = 1'b1; iss_addr = 4'd0;
      #1;
      check("z_r0_read", 32'(rd_data[15:0]), 32'h0);
      edge_settle();
      check("z_busy0", 32'(busy_vec), 32'h0);
      check("z_cnt", 32'(busy_cnt), 32'h0);
      @(negedge clk);
      idle();
      wr1_en = 1'b1; wr1_addr = 4'd0; wr1_data = 16'h1234;
      edge_settle();
      check("z_wr1_no_err", 32'(err_wb_idle), 32'h0);

      // idle writeback sets the sticky error
      @(negedge clk);
      idle();
      wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 16'h0BAD;
      edge_settle();
      check("err_set", 32'(err_wb_idle), 32'h1);
      @(negedge clk);
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("err_sticky", 32'(err_wb_idle), 32'h1);

      // dual-write collision
      @(negedge clk);
      wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 16'h1111;
      wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 16'h2222;
      set_rd(4'd5, 4'd7);
      #1;
      check("col_same_cycle", 32'(rd_data[31:16]), 32'h1111);
      @(negedge clk);
      idle();
      #1;
      check("col_stored", 32'(rd_data[31:16]), 32'h1111);

      // asynchronous reset mid-run
      @(negedge clk);
      iss_en = 1'b1; iss_addr = 4'd11;
      edge_settle();
      check("pre_rst_cnt", 32'(busy_cnt), 32'h1);
      @(negedge clk);
      idle();
      set_rd(4'd5, 4'd3);
      #1;
      rd0 = rd_data[15:0];
      rd1 = rd_data[31:16];
      check("pre_rst_r5", 32'(rd0), 32'h0BAD);
      check("pre_rst_r3", 32'(rd1), 32'h3333);
      rst = 1'b0;
      #1;
      check("arst_rd0", 32'(rd_data[15:0]), 32'h0);
      check("arst_rd1", 32'(rd_data[31:16]), 32'h0);
      check("arst_busy_vec", 32'(busy_vec), 32'h0);
      check("arst_cnt", 32'(busy_cnt), 32'h0);
      check("arst_err", 32'(err_wb_idle), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_r5", 32'(rd_data[15:0]), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
